// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, per-channel debounce, press pulse and toggle.
// Define REFLEX_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_conditioner #(
  parameter int N_BUTTONS       = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [N_BUTTONS-1:0] raw_buttons,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] pressed_pulse,
  output logic [N_BUTTONS-1:0] toggle_state,
  output logic                 any_pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_DELAY < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [N_BUTTONS-1:0] sync1_q, sync1_d;
  logic [N_BUTTONS-1:0] sync2_q, sync2_d;
  logic [N_BUTTONS-1:0] level_q, level_d;
  logic [N_BUTTONS-1:0] armed_q, armed_d;
  logic [N_BUTTONS-1:0] pulse_q, pulse_d;
  logic [N_BUTTONS-1:0] toggle_q, toggle_d;
  logic [N_BUTTONS-1:0] press;
  logic [N_BUTTONS-1:0] rep;
  logic                 any_q, any_d;
  logic [1:0]           fill_q, fill_d;
  logic [CW-1:0]        cnt_q [N_BUTTONS];
  logic [CW-1:0]        cnt_d [N_BUTTONS];

  // A channel arms only once sync2 has seen it low after reset,
  // so a button held through reset never produces a press.
  always_comb begin
    sync1_d = raw_buttons;
    sync2_d = sync1_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    level_d = level_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    press   = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (fill_q == 2'd2 && !level_q[i] && !sync2_q[i])
        armed_d[i] = 1'b1;
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = '0;
        if (armed_q[i] || !sync2_q[i])
          level_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      press[i] = ~level_q[i] & level_d[i];
    end
  end

`ifdef REFLEX_AUTOREPEAT_EN
  localparam int TW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [TW-1:0] T_FIRST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_NEXT  = TW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] T_LOOP  = TW'(REPEAT_DELAY);

  logic [TW-1:0] tmr_q [N_BUTTONS];
  logic [TW-1:0] tmr_d [N_BUTTONS];

  // Timer holds cycles since press; it loops between T_LOOP and T_NEXT.
  always_comb begin
    rep = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      tmr_d[i] = '0;
      if (level_q[i] && !clear) begin
        if (tmr_q[i] == T_FIRST || tmr_q[i] == T_NEXT)
          rep[i] = 1'b1;
        if (tmr_q[i] == T_NEXT)
          tmr_d[i] = T_LOOP;
        else
          tmr_d[i] = tmr_q[i] + TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) tmr_q <= '{default: '0};
    else       tmr_q <= tmr_d;
  end
`else
  assign rep = '0;
`endif

  always_comb begin
    pulse_d  = '0;
    toggle_d = '0;
    if (!clear) begin
      pulse_d  = press | rep;
      toggle_d = toggle_q ^ press;
    end
    any_d = |pulse_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      armed_q  <= '0;
      pulse_q  <= '0;
      toggle_q <= '0;
      any_q    <= 1'b0;
      fill_q   <= 2'd0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      armed_q  <= armed_d;
      pulse_q  <= pulse_d;
      toggle_q <= toggle_d;
      any_q    <= any_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level         = level_q;
  assign pressed_pulse = pulse_q;
  assign toggle_state  = toggle_q;
  assign any_pressed   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a press-pulse scoreboard.
// Build with REFLEX_AUTOREPEAT_EN to also exercise hold auto-repeat.
module tb_button_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] raw_buttons = 8'h00;
  logic [7:0] level, pressed_pulse, toggle_state;
  logic       any_pressed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] pulse;
    logic [7:0] tog;
  } exp_t;

  exp_t sb[$];

  button_conditioner dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .raw_buttons   (raw_buttons),
    .level         (level),
    .pressed_pulse (pressed_pulse),
    .toggle_state  (toggle_state),
    .any_pressed   (any_pressed)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called right after driving at a negedge: sample edge is cyc+1,
  // debounced press shows 5 edges later.
  task automatic push(input int ofs, input logic [7:0] p,
                      input logic [7:0] t);
    exp_t e;
    e.due   = cyc + 6 + ofs;
    e.pulse = p;
    e.tog   = t;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && (pressed_pulse !== 8'h00 || any_pressed !== 1'b0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {24'h0, pressed_pulse}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.due);
        chk("pulse_value", {24'h0, pressed_pulse}, {24'h0, e.pulse});
        chk("pulse_toggle", {24'h0, toggle_state}, {24'h0, e.tog});
        chk("any_pressed", {31'h0, any_pressed}, 32'h1);
      end
    end
  end

  int pat [7] = '{1, 1, 0, 1, 1, 0, 1};

  initial begin
    // held through reset
    raw_buttons = 8'hFF;
    reset = 1'b1;
    idle(3);
    chk("rst_level", {24'h0, level}, 32'h0);
    chk("rst_pulse", {24'h0, pressed_pulse}, 32'h0);
    chk("rst_toggle", {24'h0, toggle_state}, 32'h0);
    chk("rst_any", {31'h0, any_pressed}, 32'h0);
    reset = 1'b0;
    idle(20);
    chk("held_level", {24'h0, level}, 32'h0);
    chk("held_toggle", {24'h0, toggle_state}, 32'h0);
    raw_buttons = 8'h00;
    idle(8);

    // clean presses on bit 0
    raw_buttons = 8'h01;
    push(0, 8'h01, 8'h01);
    idle(4);
    chk("lvl_before", {24'h0, level}, 32'h0);
    idle(6);
    chk("press1_level", {24'h0, level}, 32'h01);
    chk("press1_toggle", {24'h0, toggle_state}, 32'h01);
    raw_buttons = 8'h00;
    idle(10);
    chk("rel1_level", {24'h0, level}, 32'h0);
    chk("rel1_toggle", {24'h0, toggle_state}, 32'h01);
    raw_buttons = 8'h01;
    push(0, 8'h01, 8'h00);
    idle(10);
    chk("press2_toggle", {24'h0, toggle_state}, 32'h00);
    raw_buttons = 8'h00;
    idle(10);

    // bouncing bit 3
    for (int i = 0; i < 7; i++) begin
      raw_buttons = (pat[i] != 0) ? 8'h08 : 8'h00;
      if (i == 6) push(0, 8'h08, 8'h08);
      idle(1);
    end
    idle(12);
    chk("bounce_level", {24'h0, level}, 32'h08);
    raw_buttons = 8'h00;
    idle(10);
    chk("bounce_rel_tog", {24'h0, toggle_state}, 32'h08);

    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear1_toggle", {24'h0, toggle_state}, 32'h00);

    // simultaneous presses
    raw_buttons = 8'hA5;
    push(0, 8'hA5, 8'hA5);
    idle(10);
    chk("simul_level", {24'h0, level}, 32'hA5);
    chk("simul_toggle", {24'h0, toggle_state}, 32'hA5);
    raw_buttons = 8'h00;
    idle(10);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;

    // clear with button 1 held
    raw_buttons = 8'h0F;
    push(0, 8'h0F, 8'h0F);
    idle(10);
    raw_buttons = 8'h02;
    idle(10);
    chk("pre_clr_toggle", {24'h0, toggle_state}, 32'h0F);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clr_toggle", {24'h0, toggle_state}, 32'h00);
    chk("clr_level", {24'h0, level}, 32'h02);
    idle(15);
    raw_buttons = 8'h00;
    idle(10);
    raw_buttons = 8'h02;
    push(0, 8'h02, 8'h02);
    idle(10);
    raw_buttons = 8'h00;
    idle(10);

    // clear lands on the completing press edge
    raw_buttons = 8'h10;
    idle(5);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("drop_level", {24'h0, level}, 32'h10);
    chk("drop_toggle", {24'h0, toggle_state}, 32'h00);
    idle(10);
    raw_buttons = 8'h00;
    idle(10);

`ifdef REFLEX_AUTOREPEAT_EN
    raw_buttons = 8'h04;
    push(0, 8'h04, 8'h04);
    push(64, 8'h04, 8'h04);
    push(80, 8'h04, 8'h04);
    push(96, 8'h04, 8'h04);
    push(112, 8'h04, 8'h04);
    idle(121);
    chk("rep_toggle", {24'h0, toggle_state}, 32'h04);
    raw_buttons = 8'h00;
    idle(12);
`endif

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
